// File: rtl/clk_div_multi_if.sv
// rtl/clk_div_multi_if.sv - divisor configuration handshake for clk_div_multi
interface clk_div_multi_if #(
    parameter int NCH = 2,
    parameter int W   = 8
);
    localparam int CHW = (NCH > 1) ? $clog2(NCH) : 1;

    logic           cfg_valid;
    logic           cfg_ready;
    logic [CHW-1:0] cfg_ch;
    logic [W-1:0]   cfg_div;

    modport master (output cfg_valid, output cfg_ch, output cfg_div, input cfg_ready);
    modport slave  (input cfg_valid, input cfg_ch, input cfg_div, output cfg_ready);
endinterface

// File: rtl/clk_div_multi.sv
// rtl/clk_div_multi.sv - multi-channel programmable clock divider with glitch-free divisor swap
module clk_div_multi #(
    parameter int NCH      = 2,
    parameter int W        = 8,
    parameter int DIV_INIT = 4
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           en,
    input  logic           sync,
    clk_div_multi_if.slave cfg,
    output logic [NCH-1:0] clkout,
    output logic [NCH-1:0] tick
);
    localparam int CHW = (NCH > 1) ? $clog2(NCH) : 1;
    localparam int DI  = (DIV_INIT < 2) ? 2 : DIV_INIT;
    localparam logic [W-1:0] D_RST = W'(DI);

    function automatic logic [W-1:0] clamp_div(input logic [W-1:0] v);
        return (v < W'(2)) ? W'(2) : v;
    endfunction

    logic [NCH-1:0]      pf;
    logic [2**CHW-1:0]   pf_pad;
    logic                accept;

    // Unused channel addresses read as "not pending" so they are always ready.
    always_comb begin
        pf_pad          = '0;
        pf_pad[NCH-1:0] = pf;
    end

    assign cfg.cfg_ready = ~pf_pad[cfg.cfg_ch];
    assign accept        = cfg.cfg_valid & cfg.cfg_ready;

    for (genvar i = 0; i < NCH; i++) begin : g_ch
        logic [W-1:0] d;
        logic [W-1:0] p;
        logic [W-1:0] cnt;
        logic [W-1:0] cnt_next;
        logic         wrap;
        logic         wr;
        logic         ck_q;
        logic         tk_q;

        assign wrap     = (cnt == d - W'(1));
        assign cnt_next = wrap ? '0 : cnt + W'(1);
        assign wr       = accept && (cfg.cfg_ch == CHW'(i));

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                d     <= D_RST;
                p     <= '0;
                pf[i] <= 1'b0;
                cnt   <= '0;
                ck_q  <= 1'b0;
                tk_q  <= 1'b0;
            end else begin
                // A write can only land while pf is clear, so it never collides with a swap.
                if (wr) begin
                    p     <= clamp_div(cfg.cfg_div);
                    pf[i] <= 1'b1;
                end
                if (sync) begin
                    cnt  <= '0;
                    ck_q <= 1'b0;
                    tk_q <= 1'b0;
                    if (pf[i]) begin
                        d     <= p;
                        pf[i] <= 1'b0;
                    end
                end else if (en) begin
                    cnt  <= cnt_next;
                    tk_q <= wrap;
                    ck_q <= (cnt_next >= (d >> 1));
                    if (wrap && pf[i]) begin
                        d     <= p;
                        pf[i] <= 1'b0;
                    end
                end else begin
                    tk_q <= 1'b0;
                end
            end
        end

        assign clkout[i] = ck_q;
        assign tick[i]   = tk_q;
    end
endmodule

// File: tb/tb_clk_div_multi.sv
// tb/tb_clk_div_multi.sv - randomized scoreboard bench for clk_div_multi
module tb_clk_div_multi;
    localparam int NCH = 3;
    localparam int W   = 8;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic           en = 1'b0;
    logic           sync = 1'b0;
    logic [NCH-1:0] clkout;
    logic [NCH-1:0] tick;

    clk_div_multi_if #(.NCH(NCH), .W(W)) cfg_if ();

    clk_div_multi #(.NCH(NCH), .W(W), .DIV_INIT(4)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .en     (en),
        .sync   (sync),
        .cfg    (cfg_if),
        .clkout (clkout),
        .tick   (tick)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic           rdy;
        logic [NCH-1:0] ck;
        logic [NCH-1:0] tk;
    } exp_t;

    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;
    logic act_rdy;

    int             md  [NCH];
    int             mp  [NCH];
    int             me  [NCH];
    bit             mpf [NCH];
    logic [NCH-1:0] mck;
    logic [NCH-1:0] mtk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < NCH; i++) begin
            md[i] = 4; mp[i] = 0; me[i] = 0; mpf[i] = 0;
        end
        mck = '0;
        mtk = '0;
    endtask

    // One clock edge of the reference: position within the period, period length, pending divisor.
    task automatic model_step(input bit e_en, input bit e_sync, input bit v, input int ch,
                              input int dv, output bit rdy);
        bit acc;
        rdy = (ch < NCH) ? !mpf[ch] : 1'b1;
        acc = v && rdy;
        for (int i = 0; i < NCH; i++) begin
            bit had_pf;
            had_pf = mpf[i];
            if (e_sync) begin
                me[i] = 0; mck[i] = 0; mtk[i] = 0;
                if (had_pf) begin md[i] = mp[i]; mpf[i] = 0; end
            end else if (e_en) begin
                me[i] = me[i] + 1;
                mtk[i] = 0;
                if (me[i] == md[i]) begin
                    me[i] = 0;
                    mtk[i] = 1;
                end
                mck[i] = (me[i] >= md[i] / 2);
                if (mtk[i] && had_pf) begin md[i] = mp[i]; mpf[i] = 0; end
            end else begin
                mtk[i] = 0;
            end
            if (acc && ch == i) begin
                mp[i]  = (dv < 2) ? 2 : dv;
                mpf[i] = 1;
            end
        end
    endtask

    task automatic do_reset();
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_clkout", 32'(clkout), 32'(0));
        chk("async_rst_tick", 32'(tick), 32'(0));
        @(posedge clk);
        @(negedge clk);
        cfg_if.cfg_valid = 1'b0;
        cfg_if.cfg_ch    = 2'($urandom_range(0, 3));
        #1;
        chk("rst_ready", 32'(cfg_if.cfg_ready), 32'(1));
        rst_n = 1'b1;
        model_reset();
    endtask

    initial begin
        forever begin
            @(negedge clk);
            #2 act_rdy = cfg_if.cfg_ready;
            @(posedge clk);
            #1;
            if (sb.size() > 0) begin
                exp_t ex;
                ex = sb.pop_front();
                chk("cfg_ready", 32'(act_rdy), 32'(ex.rdy));
                chk("clkout", 32'(clkout), 32'(ex.ck));
                chk("tick", 32'(tick), 32'(ex.tk));
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL timeout checks=%0d", checks);
        $fatal(1, "timeout");
    end

    initial begin
        cfg_if.cfg_valid = 1'b0;
        cfg_if.cfg_ch    = '0;
        cfg_if.cfg_div   = '0;
        model_reset();
        repeat (3) @(negedge clk);
        chk("init_clkout", 32'(clkout), 32'(0));
        chk("init_tick", 32'(tick), 32'(0));
        chk("init_ready", 32'(cfg_if.cfg_ready), 32'(1));
        rst_n = 1'b1;
        for (int cyc = 0; cyc < 20000; cyc++) begin
            bit e_en, e_sync, v, rdy;
            int ch, dv;
            exp_t ex;
            if (cyc != 0) @(negedge clk);
            if (cyc % 5000 == 4999) do_reset();
            e_en   = (cyc < 40) ? 1'b1 : ($urandom_range(0, 9) != 0);
            e_sync = (cyc < 40) ? 1'b0 : ($urandom_range(0, 39) == 0);
            v      = (cyc < 40) ? 1'b0 : ($urandom_range(0, 4) == 0);
            ch     = $urandom_range(0, 3);
            case ($urandom_range(0, 7))
                0: dv = 0;
                1: dv = 1;
                2: dv = 2;
                3: dv = 3;
                4: dv = 255;
                5: dv = 254;
                default: dv = $urandom_range(4, 12);
            endcase
            en               = e_en;
            sync             = e_sync;
            cfg_if.cfg_valid = v;
            cfg_if.cfg_ch    = 2'(ch);
            cfg_if.cfg_div   = 8'(dv);
            model_step(e_en, e_sync, v, ch, dv, rdy);
            ex.rdy = rdy;
            ex.ck  = mck;
            ex.tk  = mtk;
            sb.push_back(ex);
        end
        @(negedge clk);
        en = 1'b0; sync = 1'b0; cfg_if.cfg_valid = 1'b0;
        @(posedge clk);
        #2;
        chk("scoreboard_drained", 32'(sb.size()), 32'(0));
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
